mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
- Iterative multiply/divide unit beside the ALU in the EX stage; owns the HI/LO register pair.
- Parametrised in operand width and produces MULT/MULTU/DIV/DIVU results over multiple cycles.
- Also takes direct HI/LO writes (MTHI/MTLO).
- Pipeline control stalls any HI/LO-dependent instruction while `busy` is high.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- STEPS_PER_CYCLE, 1, iteration steps per clock; must divide WIDTH evenly. LATENCY = WIDTH/STEPS_PER_CYCLE.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- start  input  1  request; op/A/B are valid this cycle.
- op  input  4  operation code from the shared constants file.
- A  input  WIDTH  operand rs (dividend / multiplicand / MTHI/MTLO source).
- B  input  WIDTH  operand rt (divisor / multiplier).
- flush  input  1  abort the in-flight operation (exception or branch squash).
- busy  output  1  operation in flight.
- done  output  1  one-cycle pulse when HI/LO take a new result.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset: when reset_n=0 at a rising edge, all of the following clear to 0: hi, lo, busy, done, FSM state (IDLE), counters and internal operands. Reset overrides start and flush.
- FSM states: IDLE, RUN, FIX.
- IDLE → RUN on start with op in {MULT, MULTU, DIV, DIVU}.
  - Operands are latched at that edge.
  - For signed ops, absolute values are latched and the result signs recorded.
- RUN: one step per STEPS_PER_CYCLE per cycle.
  - Multiply: shift-add.
  - Divide: restoring shift-subtract.
  - A counter runs from LATENCY-1 down to 0.
- RUN → FIX after the final step.
- FIX: apply sign correction, write hi/lo, pulse done, go to IDLE.
- busy is high in RUN and FIX: exactly LATENCY+1 cycles, starting the cycle after start is accepted.
- hi/lo change only on the edge that ends FIX. done is high the cycle after that edge, in the same cycle busy is first low.
- Multiply: {hi,lo} = full 2*WIDTH product. MULT is signed; MULTU is unsigned.
- Divide: lo = quotient, hi = remainder.
  - Signed quotient truncates toward zero.
  - Remainder takes the sign of the dividend.
  - Example: -7/2 gives lo = -3, hi = -1.
- Divide by zero (B=0), detected at start:
  - Still takes the full LATENCY+1 cycles.
  - Result: lo = all ones, hi = A.
- Signed overflow (most-negative / -1): lo = most-negative, hi = 0. No trap.
- MTHI/MTLO: when start is high in IDLE, the write lands on the next edge. busy stays low and done is not pulsed.
- start while busy: ignored entirely. The pipeline must not issue it; no queueing.
- Unknown op on start: ignored, state stays IDLE.
- flush in RUN or FIX: return to IDLE next edge with busy=0 and done=0; hi/lo unchanged.
- flush in IDLE: no effect. If start and flush are both high in IDLE, flush wins and nothing is accepted.
- A flush and FIX completion on the same edge: flush wins and no write occurs.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined:
  - Adds ops MADD, MADDU, MSUB, MSUBU.
  - The product is computed as for MULT/MULTU.
  - In FIX, {hi,lo} ← {hi,lo} ± product, mod 2^(2*WIDTH).
  - Timing is identical to multiply.
- Undefined: these op codes count as unknown and are ignored. No accumulate adder is synthesised.

Decomposition:
- Shared constants file holds:
  - the op encodings mduMult, mduMultU, mduDiv, mduDivU, mduMthi, mduMtlo, mduMadd, mduMaddU, mduMsub, mduMsubU, in a 4-bit field distinct from the ALU ctrl space;
  - the FSM state encodings.
- One natural sub-module, mdu_iter_step: combinational single step (add-or-pass for multiply, trial-subtract for divide), instantiated STEPS_PER_CYCLE times in a chain.

Test Plan:
- MULTU, A=0xFFFFFFFF, B=0xFFFFFFFF → busy for 33 cycles; then hi=0xFFFFFFFE, lo=0x00000001, done pulses once.
- MULT, A=-3, B=5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- DIV, A=-7, B=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU, A=100, B=7 → lo=14, hi=2.
- DIV, B=0, A=0x12345678 → lo=0xFFFFFFFF, hi=0x12345678, same latency. DIV 0x80000000 / -1 → lo=0x80000000, hi=0.
- MTHI 0xAAAA0000 then MULT flushed mid-RUN (cycle 10) → hi=0xAAAA0000, lo unchanged, busy=0 next cycle, no done. start pulsed while busy → result matches the original op only.
- reset_n low during RUN → next cycle busy=0, hi=lo=0. With MDU_MADD_EN: hi=0, lo=10, MADD 3×4 → lo=22.

Source files
------------

// File: rtl/mult_div_unit_pkg.sv
// Shared constants for the multiply/divide unit: op encodings (4-bit field,
// separate from the ALU control space) and FSM state encodings.
package mult_div_unit_pkg;

   typedef enum logic [3:0] {
      mduNone  = 4'h0,
      mduMult  = 4'h1,
      mduMultU = 4'h2,
      mduDiv   = 4'h3,
      mduDivU  = 4'h4,
      mduMthi  = 4'h5,
      mduMtlo  = 4'h6,
      mduMadd  = 4'h7,
      mduMaddU = 4'h8,
      mduMsub  = 4'h9,
      mduMsubU = 4'hA
   } mdu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIX  = 2'd2
   } mdu_state_e;

endpackage

// File: rtl/mult_div_unit_iter_step.sv
// One combinational iteration of the multiply/divide datapath.
// Multiply: add multiplicand into the high half if the multiplier LSB is set,
// then shift {carry,hi,lo} right by one.
// Divide: shift {hi,lo} left by one, trial-subtract the divisor from hi and
// keep the difference when it does not borrow; the quotient bit enters lo.
module mdu_iter_step #(
   parameter int WIDTH = 32
) (
   input  logic             is_div_i,
   input  logic [WIDTH-1:0] hi_i,
   input  logic [WIDTH-1:0] lo_i,
   input  logic [WIDTH-1:0] m_i,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);

   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   shifted;
   logic [WIDTH-1:0] diff;
   logic             ge;

   // Single add-or-pass / trial-subtract step
   always_comb begin
      sum     = {1'b0, hi_i} + (lo_i[0] ? {1'b0, m_i} : '0);
      shifted = {hi_i, lo_i[WIDTH-1]};
      ge      = (shifted >= {1'b0, m_i});
      // Partial remainder stays below the divisor, so the difference fits in WIDTH bits.
      diff    = shifted[WIDTH-1:0] - m_i;
      if (is_div_i) begin
         hi_o = ge ? diff : shifted[WIDTH-1:0];
         lo_o = {lo_i[WIDTH-2:0], ge};
      end else begin
         hi_o = sum[WIDTH:1];
         lo_o = {sum[0], lo_i[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit owning the HI/LO register pair.
// MULT/MULTU/DIV/DIVU run for LATENCY+1 busy cycles; MTHI/MTLO write directly.
// Optional macro MDU_MADD_EN adds MADD/MADDU/MSUB/MSUBU accumulate ops.
module mult_div_unit
   import mult_div_unit_pkg::*;
#(
   parameter int WIDTH           = 32,
   parameter int STEPS_PER_CYCLE = 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int LATENCY = WIDTH / STEPS_PER_CYCLE;
   localparam int CW      = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   mdu_state_e       state_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] ph_q, pl_q, m_q;
   logic             is_div_q, neg_q, neg_rem_q, div0_q;
   logic [WIDTH-1:0] hi_q, lo_q;
   logic             busy_q, done_q;
`ifdef MDU_MADD_EN
   logic             acc_q, sub_q;
`endif

   logic             is_mul_op, is_div_op, sgn_op, a_neg, b_neg;
   logic [WIDTH-1:0] a_abs, b_abs, quo, rem;
   logic [2*WIDTH-1:0] prod, prod_s, res_d;

   logic [WIDTH-1:0] hi_c [0:STEPS_PER_CYCLE];
   logic [WIDTH-1:0] lo_c [0:STEPS_PER_CYCLE];

   assign hi_c[0] = ph_q;
   assign lo_c[0] = pl_q;

   for (genvar g = 0; g < STEPS_PER_CYCLE; g++) begin : g_step
      mdu_iter_step #(.WIDTH(WIDTH)) u_step (
         .is_div_i (is_div_q),
         .hi_i     (hi_c[g]),
         .lo_i     (lo_c[g]),
         .m_i      (m_q),
         .hi_o     (hi_c[g+1]),
         .lo_o     (lo_c[g+1])
      );
   end

   // Start decode, operand magnitudes and final sign-corrected result
   always_comb begin
      is_div_op = (op == mduDiv) || (op == mduDivU);
      is_mul_op = (op == mduMult) || (op == mduMultU)
`ifdef MDU_MADD_EN
                  || (op == mduMadd) || (op == mduMaddU)
                  || (op == mduMsub) || (op == mduMsubU)
`endif
                  ;
      sgn_op    = (op == mduMult) || (op == mduDiv)
`ifdef MDU_MADD_EN
                  || (op == mduMadd) || (op == mduMsub)
`endif
                  ;
      a_neg     = sgn_op & A[WIDTH-1];
      b_neg     = sgn_op & B[WIDTH-1];
      a_abs     = a_neg ? ('0 - A) : A;
      b_abs     = b_neg ? ('0 - B) : B;

      prod      = {ph_q, pl_q};
      prod_s    = neg_q ? ('0 - prod) : prod;
      quo       = div0_q ? '1 : (neg_q ? ('0 - pl_q) : pl_q);
      rem       = neg_rem_q ? ('0 - ph_q) : ph_q;
      res_d     = is_div_q ? {rem, quo} : prod_s;
`ifdef MDU_MADD_EN
      if (acc_q) begin
         res_d = sub_q ? ({hi_q, lo_q} - prod_s) : ({hi_q, lo_q} + prod_s);
      end
`endif
   end

   // Control FSM, iteration registers and HI/LO with registered status outputs
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         ph_q      <= '0;
         pl_q      <= '0;
         m_q       <= '0;
         is_div_q  <= 1'b0;
         neg_q     <= 1'b0;
         neg_rem_q <= 1'b0;
         div0_q    <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
`ifdef MDU_MADD_EN
         acc_q     <= 1'b0;
         sub_q     <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start && !flush) begin
                  if (is_mul_op || is_div_op) begin
                     state_q   <= ST_RUN;
                     busy_q    <= 1'b1;
                     cnt_q     <= CW'(LATENCY - 1);
                     ph_q      <= '0;
                     pl_q      <= is_div_op ? a_abs : b_abs;
                     m_q       <= is_div_op ? b_abs : a_abs;
                     is_div_q  <= is_div_op;
                     neg_q     <= a_neg ^ b_neg;
                     neg_rem_q <= a_neg;
                     div0_q    <= is_div_op && (B == '0);
`ifdef MDU_MADD_EN
                     acc_q     <= (op == mduMadd) || (op == mduMaddU) ||
                                  (op == mduMsub) || (op == mduMsubU);
                     sub_q     <= (op == mduMsub) || (op == mduMsubU);
`endif
                  end else if (op == mduMthi) begin
                     hi_q <= A;
                  end else if (op == mduMtlo) begin
                     lo_q <= A;
                  end
               end
            end
            ST_RUN: begin
               if (flush) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  ph_q <= hi_c[STEPS_PER_CYCLE];
                  pl_q <= lo_c[STEPS_PER_CYCLE];
                  if (cnt_q == '0) begin
                     state_q <= ST_FIX;
                  end else begin
                     cnt_q <= cnt_q - 1'b1;
                  end
               end
            end
            ST_FIX: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
               if (!flush) begin
                  {hi_q, lo_q} <= res_d;
                  done_q       <= 1'b1;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: an arithmetic reference model checked
// every cycle, directed cases with literal expectations, then random traffic.
module tb_mult_div_unit;
   import mult_div_unit_pkg::*;

   localparam int W   = 32;
   localparam int LAT = 32;

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic         start = 1'b0;
   logic         flush = 1'b0;
   logic [3:0]   op = 4'h0;
   logic [W-1:0] A = '0;
   logic [W-1:0] B = '0;
   logic         busy, done;
   logic [W-1:0] hi, lo;

   always #5 clk = ~clk;

   mult_div_unit #(.WIDTH(W), .STEPS_PER_CYCLE(1)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (start),
      .op      (op),
      .A       (A),
      .B       (B),
      .flush   (flush),
      .busy    (busy),
      .done    (done),
      .hi      (hi),
      .lo      (lo)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   logic [W-1:0]   m_hi = '0, m_lo = '0;
   bit             m_done = 1'b0;
   int             pend = 0;
   logic [2*W-1:0] pend_res = '0;
   int             pend_kind = 0;

   function automatic bit is_long(input logic [3:0] o);
      bit r;
      r = (o == mduMult) || (o == mduMultU) || (o == mduDiv) || (o == mduDivU);
`ifdef MDU_MADD_EN
      r = r || (o == mduMadd) || (o == mduMaddU) || (o == mduMsub) || (o == mduMsubU);
`endif
      return r;
   endfunction

   function automatic logic [2*W-1:0] ref_result(input logic [3:0] o,
                                                 input logic [W-1:0] a,
                                                 input logic [W-1:0] b);
      longint sa, sb;
      int     q, r;
      logic [63:0] ua, ub;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'h0, a};
      ub = {32'h0, b};
      case (o)
         mduMult, mduMadd, mduMsub:    return 64'(sa * sb);
         mduMultU, mduMaddU, mduMsubU: return ua * ub;
         mduDiv: begin
            if (b == 0) return {a, 32'hFFFF_FFFF};
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, a};
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
            return {r, q};
         end
         mduDivU: begin
            if (b == 0) return {a, 32'hFFFF_FFFF};
            return {a % b, a / b};
         end
         default: return '0;
      endcase
   endfunction

   always @(posedge clk) begin
      if (!reset_n) begin
         m_hi = '0; m_lo = '0; m_done = 1'b0; pend = 0;
      end else begin
         m_done = 1'b0;
         if (pend > 0) begin
            if (flush) pend = 0;
            else begin
               pend--;
               if (pend == 0) begin
                  if (pend_kind == 1)      {m_hi, m_lo} = {m_hi, m_lo} + pend_res;
                  else if (pend_kind == 2) {m_hi, m_lo} = {m_hi, m_lo} - pend_res;
                  else                     {m_hi, m_lo} = pend_res;
                  m_done = 1'b1;
               end
            end
         end else if (start && !flush) begin
            if (is_long(op)) begin
               pend_res  = ref_result(op, A, B);
               pend_kind = (op == mduMadd || op == mduMaddU) ? 1 :
                           (op == mduMsub || op == mduMsubU) ? 2 : 0;
               pend      = LAT + 1;
            end else if (op == mduMthi) m_hi = A;
            else if (op == mduMtlo)     m_lo = A;
         end
      end
   end

   // Per-cycle comparison against the model
   always @(negedge clk) begin
      chk("busy", 64'(busy), 64'(pend > 0));
      chk("done", 64'(done), 64'(m_done));
      chk("hi",   64'(hi),   64'(m_hi));
      chk("lo",   64'(lo),   64'(m_lo));
   end

   // ---------------- stimulus helpers ----------------
   task automatic pulse(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic fl);
      @(negedge clk);
      op = o; A = a; B = b; start = 1'b1; flush = fl;
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
   endtask

   task automatic run_op(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int bcyc, output logic dn);
      pulse(o, a, b, 1'b0);
      bcyc = 0;
      while (busy && bcyc < 100) begin
         bcyc++;
         @(negedge clk);
      end
      dn = done;
   endtask

   function automatic logic [W-1:0] rnd_operand();
      case ($urandom_range(0, 5))
         0: return '0;
         1: return '1;
         2: return 32'h8000_0000;
         3: return W'($urandom_range(0, 20));
         default: return W'($urandom);
      endcase
   endfunction

   int   bc;
   logic dn;

   initial begin
      repeat (3) @(negedge clk);
      chk("reset_hi", 64'(hi), 64'h0);
      chk("reset_lo", 64'(lo), 64'h0);
      chk("reset_busy", 64'(busy), 64'h0);
      chk("reset_done", 64'(done), 64'h0);
      reset_n = 1'b1;

      run_op(mduMultU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, bc, dn);
      chk("multu_latency", 64'(bc), 64'd33);
      chk("multu_done", 64'(dn), 64'h1);
      chk("multu_hi", 64'(hi), 64'hFFFF_FFFE);
      chk("multu_lo", 64'(lo), 64'h0000_0001);
      @(negedge clk);
      chk("multu_done_once", 64'(done), 64'h0);

      run_op(mduMult, 32'hFFFF_FFFD, 32'd5, bc, dn);
      chk("mult_hi", 64'(hi), 64'hFFFF_FFFF);
      chk("mult_lo", 64'(lo), 64'hFFFF_FFF1);

      run_op(mduDiv, 32'hFFFF_FFF9, 32'd2, bc, dn);
      chk("div_lo", 64'(lo), 64'hFFFF_FFFD);
      chk("div_hi", 64'(hi), 64'hFFFF_FFFF);

      run_op(mduDivU, 32'd100, 32'd7, bc, dn);
      chk("divu_lo", 64'(lo), 64'd14);
      chk("divu_hi", 64'(hi), 64'd2);

      run_op(mduDiv, 32'h1234_5678, 32'h0, bc, dn);
      chk("div0_latency", 64'(bc), 64'd33);
      chk("div0_lo", 64'(lo), 64'hFFFF_FFFF);
      chk("div0_hi", 64'(hi), 64'h1234_5678);

      run_op(mduDiv, 32'h8000_0000, 32'hFFFF_FFFF, bc, dn);
      chk("ovf_lo", 64'(lo), 64'h8000_0000);
      chk("ovf_hi", 64'(hi), 64'h0);

      pulse(mduMthi, 32'hAAAA_0000, 32'h0, 1'b0);
      chk("mthi_busy", 64'(busy), 64'h0);
      chk("mthi_hi", 64'(hi), 64'hAAAA_0000);

      // MULT squashed partway through RUN
      pulse(mduMult, 32'd5, 32'd6, 1'b0);
      repeat (9) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("flush_busy", 64'(busy), 64'h0);
      chk("flush_done", 64'(done), 64'h0);
      chk("flush_hi", 64'(hi), 64'hAAAA_0000);
      chk("flush_lo", 64'(lo), 64'h8000_0000);

      // Second start while busy must be dropped
      pulse(mduMultU, 32'd6, 32'd7, 1'b0);
      repeat (4) @(negedge clk);
      pulse(mduDivU, 32'd100, 32'd7, 1'b0);
      bc = 0;
      while (busy && bc < 100) begin
         bc++;
         @(negedge clk);
      end
      chk("ignore_done", 64'(done), 64'h1);
      chk("ignore_hi", 64'(hi), 64'h0);
      chk("ignore_lo", 64'(lo), 64'd42);
      @(negedge clk);
      chk("ignore_noqueue", 64'(busy), 64'h0);

      pulse(4'hF, 32'd1, 32'd1, 1'b0);
      chk("unknown_busy", 64'(busy), 64'h0);

      pulse(mduMtlo, 32'h55, 32'h0, 1'b1);
      chk("idle_flush_lo", 64'(lo), 64'd42);

      // Reset taken while RUN is in progress
      pulse(mduMult, 32'd3, 32'd4, 1'b0);
      repeat (4) @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      chk("rst_run_busy", 64'(busy), 64'h0);
      chk("rst_run_hi", 64'(hi), 64'h0);
      chk("rst_run_lo", 64'(lo), 64'h0);

`ifdef MDU_MADD_EN
      pulse(mduMthi, 32'h0, 32'h0, 1'b0);
      pulse(mduMtlo, 32'd10, 32'h0, 1'b0);
      run_op(mduMadd, 32'd3, 32'd4, bc, dn);
      chk("madd_latency", 64'(bc), 64'd33);
      chk("madd_hi", 64'(hi), 64'h0);
      chk("madd_lo", 64'(lo), 64'd22);
`else
      pulse(mduMadd, 32'd3, 32'd4, 1'b0);
      chk("madd_off_busy", 64'(busy), 64'h0);
`endif

      // Random traffic, checked cycle by cycle against the model
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         reset_n = ($urandom_range(0, 299) != 0);
         start   = ($urandom_range(0, 3) == 0);
         op      = 4'($urandom_range(0, 11));
         A       = rnd_operand();
         B       = rnd_operand();
         flush   = ($urandom_range(0, 59) == 0);
      end
      @(negedge clk);
      reset_n = 1'b1; start = 1'b0; flush = 1'b0;
      repeat (40) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
